line_mem_engine: RTL and testbench

LINE_MEM_ENGINE -- requirements
Module: line_mem_engine

---
 rtl/line_mem_engine.sv | 139 +++++++++++++
 tb/tb_line_mem_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_engine.sv
// Cache-line transfer engine: splits a 512-bit line fill or writeback
// into sixteen 32-bit word commands toward a pipelined memory port.
module line_mem_engine #(
    parameter int WORDS_PER_LINE = 16,
    parameter int LINE_BITS      = 32 * WORDS_PER_LINE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST,
        RESP
    } state_t;

    localparam logic [4:0] LAST_BEAT = 5'(WORDS_PER_LINE - 1);
    localparam logic [4:0] NUM_BEATS = 5'(WORDS_PER_LINE);

    state_t                 state_q, state_d;
    logic [31:0]            base_q, base_d;
    logic [LINE_BITS-1:0]   wline_q, wline_d;
    logic [LINE_BITS-1:0]   rline_q, rline_d;
    logic [4:0]             cmd_cnt_q, cmd_cnt_d;
    logic [4:0]             data_cnt_q, data_cnt_d;
    logic                   err_q, err_d;
    logic [31:0]            beat_addr;
    logic                   rd_ok;

    assign beat_addr = base_q + {25'd0, cmd_cnt_q, 2'b00};
    // A beat is legal only while a read burst has more commands out than data back
    assign rd_ok = (state_q == RD_BURST) && (data_cnt_q < cmd_cnt_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wline_d    = wline_q;
        rline_d    = rline_q;
        cmd_cnt_d  = cmd_cnt_q;
        data_cnt_d = data_cnt_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_d     = req_addr & 32'hFFFF_FFC0;
                    wline_d    = req_wdata;
                    cmd_cnt_d  = 5'd0;
                    data_cnt_d = 5'd0;
                    state_d    = req_wr ? WR_BURST : RD_BURST;
                end
            end
            WR_BURST: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = beat_addr;
                mem_wdata = wline_q[{cmd_cnt_q[3:0], 5'd0} +: 32];
                if (mem_ready) begin
                    cmd_cnt_d = cmd_cnt_q + 5'd1;
                    if (cmd_cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RD_BURST: begin
                if (cmd_cnt_q < NUM_BEATS) begin
                    mem_valid = 1'b1;
                    mem_addr  = beat_addr;
                    if (mem_ready) begin
                        cmd_cnt_d = cmd_cnt_q + 5'd1;
                    end
                end
                if (mem_rvalid && rd_ok) begin
                    rline_d[{data_cnt_q[3:0], 5'd0} +: 32] = mem_rdata;
                    data_cnt_d = data_cnt_q + 5'd1;
                    if (data_cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mem_rvalid && !rd_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= 32'd0;
            wline_q    <= '0;
            rline_q    <= '0;
            cmd_cnt_q  <= 5'd0;
            data_cnt_q <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wline_q    <= wline_d;
            rline_q    <= rline_d;
            cmd_cnt_q  <= cmd_cnt_d;
            data_cnt_q <= data_cnt_d;
            err_q      <= err_d;
        end
    end

    assign resp_rdata = rline_q;
    assign err        = err_q;

endmodule

// File: tb/tb_line_mem_engine.sv
// Self-checking bench for line_mem_engine: vector table, random transfers
// against a line-level memory model, and hand-written error/reset sequences.
module tb_line_mem_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_wr;
    logic [31:0]  req_addr;
    logic [511:0] req_wdata;
    logic         resp_valid;
    logic [511:0] resp_rdata;
    logic         mem_valid;
    logic         mem_ready;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         err;

    line_mem_engine dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          due;
    } rbeat_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wbase;
        int          rmode;
        int          lmin;
        int          lmax;
        logic [31:0] key;
        int          exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    rbeat_t       rq[$];
    logic [63:0]  wq[$];
    int           cyc = 0;
    int           acc_cyc, resp_cyc, resp_cnt, mv_cnt, stall_err, last_due;
    int           rd_mode, lat_min, lat_max;
    logic [31:0]  cur_key;
    bit           issue = 0;
    bit           inject = 0;
    logic         prev_v = 0, prev_rdy = 0, prev_we = 0;
    logic [31:0]  prev_addr = 0, prev_wd = 0;
    logic [511:0] model_line = '0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, observe outputs.
    task automatic step();
        int lat;
        int due;
        @(negedge clk);
        cyc++;
        req_valid = issue;
        case (rd_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = (cyc % 2 == 0);
            default: mem_ready = 1'($urandom % 2);
        endcase
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        if (inject) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq[0].d;
            void'(rq.pop_front());
        end
        if (prev_v && !prev_rdy) begin
            if (!(mem_valid && mem_addr == prev_addr && mem_we == prev_we &&
                  mem_wdata == prev_wd))
                stall_err++;
        end
        if (req_valid && req_ready) begin
            acc_cyc = cyc;
            issue   = 0;
        end
        if (mem_valid) mv_cnt++;
        if (mem_valid && mem_ready) begin
            if (mem_we) begin
                wq.push_back({mem_addr, mem_wdata});
            end else begin
                lat = int'($urandom_range(lat_max, lat_min));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq.push_back('{d: mem_addr ^ cur_key, due: due});
            end
        end
        if (resp_valid) begin
            resp_cnt++;
            resp_cyc = cyc;
        end
        prev_v    = mem_valid;
        prev_rdy  = mem_ready;
        prev_addr = mem_addr;
        prev_we   = mem_we;
        prev_wd   = mem_wdata;
    endtask

    task automatic do_xfer(input logic wr, input logic [31:0] addr,
                           input logic [511:0] line, input int rmode,
                           input int lmin, input int lmax,
                           input logic [31:0] key, input int exp_lat);
        logic [31:0]  base;
        logic [511:0] exp_line;
        int           wbad;
        base = addr & 32'hFFFF_FFC0;
        wq.delete();
        resp_cnt  = 0;
        stall_err = 0;
        last_due  = 0;
        acc_cyc   = -100;
        resp_cyc  = 0;
        cur_key   = key;
        rd_mode   = rmode;
        lat_min   = lmin;
        lat_max   = lmax;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = line;
        issue     = 1;
        for (int i = 0; i < 400 && resp_cnt == 0; i++) step();
        repeat (3) step();
        chk("resp_once", resp_cnt, 1);
        if (exp_lat >= 0) chk("latency", resp_cyc - acc_cyc, exp_lat);
        if (wr) begin
            wbad = (wq.size() != 16) ? 1 : 0;
            for (int k = 0; k < 16 && k < wq.size(); k++) begin
                if (wq[k] !== {base + 32'(4 * k), line[32*k +: 32]}) wbad++;
            end
            chk("wr_beats", wbad, 0);
            chk("rdata_kept", resp_rdata, model_line);
        end else begin
            for (int k = 0; k < 16; k++)
                exp_line[32*k +: 32] = (base + 32'(4 * k)) ^ key;
            chk("no_wr_beats", wq.size(), 0);
            chk("fill_data", resp_rdata, exp_line);
            model_line = exp_line;
        end
        chk("stall_stable", stall_err, 0);
        chk("rq_drained", rq.size(), 0);
    endtask

    vec_t         vt[7];
    logic [511:0] line;
    logic [511:0] saved;

    initial begin
        rst = 1'b0;
        req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        rd_mode = 0; lat_min = 1; lat_max = 1; cur_key = 0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        vt[0] = '{1'b1, 32'h0000_1234, 32'hA0,  0, 1, 1, 32'h0,         17};
        vt[1] = '{1'b0, 32'h0000_2040, 32'h0,   0, 3, 3, 32'h0,         20};
        vt[2] = '{1'b0, 32'h0000_2040, 32'h0,   1, 1, 5, 32'h1111_0000, -1};
        vt[3] = '{1'b1, 32'hFFFF_FFC0, 32'h100, 0, 1, 1, 32'h0,         17};
        vt[4] = '{1'b0, 32'hFFFF_FFC7, 32'h0,   0, 1, 1, 32'h0,         18};
        vt[5] = '{1'b1, 32'h0000_0040, 32'h55,  2, 1, 1, 32'h0,         -1};
        vt[6] = '{1'b0, 32'h8000_0100, 32'h0,   0, 5, 5, 32'hCAFE_0000, 22};
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 16; k++) line[32*k +: 32] = vt[v].wbase + 32'(k);
            do_xfer(vt[v].wr, vt[v].addr, line, vt[v].rmode, vt[v].lmin,
                    vt[v].lmax, vt[v].key, vt[v].exp_lat);
        end

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 16; k++) line[32*k +: 32] = $urandom;
            do_xfer(1'($urandom % 2), $urandom, line, int'($urandom % 3),
                    1, 5, $urandom, -1);
        end
        chk("err_clean", err, 0);

        saved = resp_rdata;
        inject = 1;
        step();
        inject = 0;
        step();
        chk("err_set", err, 1);
        chk("stray_no_update", resp_rdata, saved);
        repeat (3) step();
        chk("err_sticky", err, 1);
        do_xfer(1'b0, 32'h0000_3000, '0, 0, 2, 2, 32'h0, 19);
        chk("err_still", err, 1);

        for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'h700 + 32'(k);
        wq.delete();
        rd_mode = 0;
        req_wr = 1; req_addr = 32'h0000_5000; req_wdata = line;
        issue = 1;
        for (int i = 0; i < 100 && wq.size() < 7; i++) step();
        chk("seven_beats", wq.size(), 7);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_mem_valid", mem_valid, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_err", err, 0);
        issue = 0;
        prev_v = 0;
        rq.delete();
        @(negedge clk);
        rst = 1'b1;
        model_line = '0;
        resp_cnt = 0;
        mv_cnt = 0;
        repeat (20) step();
        chk("post_rst_no_resp", resp_cnt, 0);
        chk("post_rst_no_cmd", mv_cnt, 0);
        chk("post_rst_ready", req_ready, 1);
        for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'h900 + 32'(k);
        do_xfer(1'b1, 32'hFFFF_FFC0, line, 0, 1, 1, 32'h0, 17);
        chk("last_addr", (wq.size() == 16) ? wq[15][63:32] : 32'd0,
            32'hFFFF_FFFC);
        chk("rdata_after_rst", resp_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
